// File: rtl/iter_div_if.sv
// iter_div_if -- request/response bundle between Execute and the iterative divider.
//   master (Execute side): drives is_flush, is_stall, en, is_signed, dividend, divisor
//                          and receives quotient, remainder, done
//   slave  (divider side): the mirror image
interface iter_div_if;
   logic        is_flush;   // abort any operation in flight
   logic        is_stall;   // downstream not ready; hold result while high
   logic        en;         // start request, level, held until done
   logic        is_signed;  // 1 = signed div/mod
   logic [31:0] dividend;   // rj
   logic [31:0] divisor;    // rkd
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        done;       // result valid

   modport master (
      output is_flush, is_stall, en, is_signed, dividend, divisor,
      input  quotient, remainder, done
   );

   modport slave (
      input  is_flush, is_stall, en, is_signed, dividend, divisor,
      output quotient, remainder, done
   );
endinterface

// File: rtl/iter_div.sv
// iter_div -- 32-bit radix-2 restoring divider (signed/unsigned div and mod).
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : iter_div_if.slave (flush/stall/en/is_signed/operands in,
//           quotient/remainder/done out)
// One quotient bit per CALC cycle, MSB first; done is visible 33 cycles after
// the start cycle (start cycle counted as cycle 1). Results are registered and
// hold until the next operation completes.
// Optional build macro DIV_EARLY_OUT_EN: divisor==0 or |dividend|<|divisor|
// skips CALC and completes in one cycle.
module iter_div (
   input  logic      clk,
   input  logic      rst_n,
   iter_div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] rem;        // partial remainder (always < divisor, fits 32b)
   logic [31:0] quo;        // dividend bits shift out, quotient bits shift in
   logic [31:0] dvs;        // divisor magnitude
   logic        sgn_q, sgn_r, dvz;
   logic [31:0] q_res, r_res;

   logic [31:0] a_abs, b_abs;
   logic        div_zero, early;
   logic [32:0] trial, diff;
   logic [31:0] rem_nxt, quo_nxt, q_fin, r_fin;
   logic        start, last, done_c;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   assign a_abs    = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
   assign b_abs    = (bus.is_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;
   assign div_zero = (bus.divisor == 32'd0);

`ifdef DIV_EARLY_OUT_EN
   assign early = div_zero || (a_abs < b_abs);
`else
   assign early = 1'b0;
`endif

   // Shift-and-subtract step; restore by keeping the shifted value on borrow.
   always_comb begin
      trial = {rem, quo[31]};
      diff  = trial - {1'b0, dvs};
      if (!diff[32]) begin
         rem_nxt = diff[31:0];
         quo_nxt = {quo[30:0], 1'b1};
      end else begin
         rem_nxt = trial[31:0];
         quo_nxt = {quo[30:0], 1'b0};
      end
      // Divide-by-zero quotient is all ones independent of sign; the remainder
      // path already reproduces the dividend (|a| then re-signed).
      q_fin = dvz   ? 32'hFFFF_FFFF : (sgn_q ? -quo_nxt : quo_nxt);
      r_fin = sgn_r ? -rem_nxt : rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      last      = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: if (bus.en) begin
                  start     = 1'b1;
                  state_nxt = early ? DONE : CALC;
               end
         CALC: if (cnt == 6'd31) begin
                  last      = 1'b1;
                  state_nxt = DONE;
               end
         DONE: begin
                  done_c = 1'b1;
                  if (!bus.is_stall) state_nxt = IDLE;
               end
         default: state_nxt = IDLE;
      endcase
      // Flush beats en and stall.
      if (bus.is_flush) begin
         state_nxt = IDLE;
         start     = 1'b0;
         last      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         sgn_q <= 1'b0;
         sgn_r <= 1'b0;
         dvz   <= 1'b0;
         q_res <= '0;
         r_res <= '0;
      end else if (start) begin
         cnt   <= '0;
         rem   <= '0;
         quo   <= a_abs;
         dvs   <= b_abs;
         sgn_q <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
         sgn_r <= bus.is_signed & bus.dividend[31];
         dvz   <= div_zero;
         if (early) begin
            q_res <= div_zero ? 32'hFFFF_FFFF : 32'd0;
            r_res <= bus.dividend;
         end
      end else if (state == CALC && !bus.is_flush) begin
         cnt <= cnt + 6'd1;
         rem <= rem_nxt;
         quo <= quo_nxt;
         if (last) begin
            q_res <= q_fin;
            r_res <= r_fin;
         end
      end
   end

   assign bus.done      = done_c;
   assign bus.quotient  = q_res;
   assign bus.remainder = r_res;

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div -- self-checking bench for iter_div. Expected results come from
// a behavioural model pushed to a scoreboard at start and popped at done.
module tb_iter_div;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   iter_div_if bus();

   iter_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
         end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
         end
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
`ifdef DIV_EARLY_OUT_EN
      e.lat = (b == 32'd0 || ma < mb) ? 1 : 33;
`else
      e.lat = 33;
`endif
      return e;
   endfunction

   // Called at posedge+1: request is sampled by the next rising edge.
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      bus.en        = 1'b1;
      bus.is_signed = s;
      bus.dividend  = a;
      bus.divisor   = b;
      sb.push_back(model(s, a, b));
   endtask

   // Edges counted from the start edge (=1) until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      bus.en = 1'b0;
   endtask

   task automatic finish_op();
      bus.en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.is_flush = 1'b0; bus.is_stall = 1'b0; bus.en = 1'b0;
      bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_q got %h exp 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_r got %h exp 0", bus.remainder); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned_stall();
      exp_t e;
      int   lat;
      bus.is_stall = 1'b1;
      start_op(1'b0, 32'd100, 32'd7);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL u100_7 latency got %0d exp %0d", lat, e.lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL u100_7 q got %h exp %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL u100_7 r got %h exp %h", bus.remainder, e.r); end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_hold done got %b exp 1 cyc %0d", bus.done, i); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL stall_hold q got %h exp %h", bus.quotient, e.q); end
      end
      bus.is_stall = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_release done got %b exp 0", bus.done); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
         errors++; $display("FAIL result_hold got %h/%h exp %h/%h", bus.quotient, bus.remainder, e.q, e.r);
      end
   endtask

   task automatic test_signed();
      logic [31:0] av[2] = '{32'hFFFF_FF9C, 32'h8000_0000};
      logic [31:0] bv[2] = '{32'd7, 32'hFFFF_FFFF};
      exp_t e;
      int   lat;
      for (int i = 0; i < 2; i++) begin
         start_op(1'b1, av[i], bv[i]);
         wait_done(lat);
         e = sb.pop_front();
         checks++; if (lat != e.lat) begin errors++; $display("FAIL signed%0d latency got %0d exp %0d", i, lat, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL signed%0d q got %h exp %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL signed%0d r got %h exp %h", i, bus.remainder, e.r); end
         finish_op();
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      int   lat;
      for (int s = 0; s < 2; s++) begin
         start_op(s[0], 32'h1234_5678, 32'd0);
         wait_done(lat);
         e = sb.pop_front();
         checks++; if (lat != e.lat) begin errors++; $display("FAIL divzero_s%0d latency got %0d exp %0d", s, lat, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL divzero_s%0d q got %h exp %h", s, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL divzero_s%0d r got %h exp %h", s, bus.remainder, e.r); end
         finish_op();
      end
   endtask

   task automatic test_flush();
      exp_t e;
      int   lat;
      logic seen;
      // Flushed operation: nothing is pushed, it must never complete.
      bus.en = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.done !== 1'b0) seen = 1'b1;
      end
      bus.is_flush = 1'b1;  // en still high: flush must win
      @(posedge clk); #1;
      if (bus.done !== 1'b0) seen = 1'b1;
      checks++; if (seen) begin errors++; $display("FAIL flush_calc done got 1 exp 0"); end
      bus.is_flush = 1'b0;
      start_op(1'b0, 32'd50, 32'd5);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL post_flush latency got %0d exp %0d", lat, e.lat); end
      checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
         errors++; $display("FAIL post_flush got %h/%h exp %h/%h", bus.quotient, bus.remainder, e.q, e.r);
      end
      // Flush in DONE beats a held stall.
      bus.is_stall = 1'b1;
      @(posedge clk); #1;
      bus.is_flush = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done done got %b exp 0", bus.done); end
      bus.is_flush = 1'b0;
      bus.is_stall = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   lat;
      bus.en = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.en = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
         errors++; $display("FAIL reset_mid got done=%b %h/%h exp 0 0/0", bus.done, bus.quotient, bus.remainder);
      end
      rst_n = 1'b1;
      start_op(1'b0, 32'd9, 32'd4);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL after_reset latency got %0d exp %0d", lat, e.lat); end
      checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
         errors++; $display("FAIL after_reset got %h/%h exp %h/%h", bus.quotient, bus.remainder, e.q, e.r);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      start_op(1'b0, 32'hFFFF_FFFF, 32'd16);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat || bus.quotient !== e.q || bus.remainder !== e.r) begin
         errors++; $display("FAIL b2b_first got lat=%0d %h/%h exp lat=%0d %h/%h", lat, bus.quotient, bus.remainder, e.lat, e.q, e.r);
      end
      finish_op();   // DONE -> IDLE edge; the next edge must start
      start_op(1'b0, 32'd3, 32'd5);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_second latency got %0d exp %0d", lat, e.lat); end
      checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
         errors++; $display("FAIL b2b_second got %h/%h exp %h/%h", bus.quotient, bus.remainder, e.q, e.r);
      end
      finish_op();
   endtask

   // Operands also change mid-CALC to show they are sampled only at start.
   task automatic test_random();
      exp_t        e;
      int          lat;
      logic [31:0] a, b;
      logic        s;
      for (int n = 0; n < 12; n++) begin
         s = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 100);
         case ($urandom_range(0, 3))
            0:       b = $urandom_range(1, 20);
            1:       b = $urandom;
            2:       b = 32'd0;
            default: b = -$urandom_range(1, 20);
         endcase
         start_op(s, a, b);
         @(posedge clk); #1;
         bus.dividend = $urandom;
         bus.divisor  = $urandom;
         wait_done(lat);
         if (lat > 0) lat = lat + 1;
         e = sb.pop_front();
         checks++; if (lat != e.lat || bus.quotient !== e.q || bus.remainder !== e.r) begin
            errors++;
            $display("FAIL rand%0d s=%b %h/%h got lat=%0d %h/%h exp lat=%0d %h/%h",
                     n, s, a, b, lat, bus.quotient, bus.remainder, e.lat, e.q, e.r);
         end
         finish_op();
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_stall();
      test_signed();
      test_div_zero();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
